ro_freq_counter: RTL and testbench
==================================

// Module: ro_freq_counter
// PURPOSE
//  Measures the frequency of one free-running ring oscillator (RO) in the system clock domain.
//  Enables the RO through ro_en, lets it settle, then counts RO rising edges over a programmable
//  window of clk cycles. Returns the count through a valid/ready handshake.
//  Sits directly downstream of the RO bank; its output feeds the reliability/aging logger.
// PARAMETERS
//  CNT_W          16   width of the edge counter and of count
//  GATE_W         16   width of gate_len (measurement window, in clk cycles)
//  SETTLE_CYCLES  4    clk cycles after ro_en rises before counting starts (min 2, covers synchronizer)
// PORTS
//  clk        in   1       system clock; the only clock of the block
//  rst_n      in   1       synchronous reset, active-low
//  ro_in      in   1       RO output; asynchronous to clk
//  start      in   1       measurement request; sampled only in IDLE
//  gate_len   in   GATE_W  window length; latched on accepted start
//  ro_en      out  1       RO enable (drives the RO's NAND control input)
//  busy       out  1       high whenever state != IDLE
//  count      out  CNT_W   measured edge count; valid while valid=1
//  overflow   out  1       count saturated during this window
//  valid      out  1       result available
//  ready      in   1       consumer accepts the result
// BEHAVIOUR
//  - Reset: on a clk edge with rst_n=0, go to IDLE. Clear ro_en, busy, count, overflow, valid,
//    both sync flops, the settle counter and the gate counter. Applies from any state, mid-operation.
//  - ro_in passes through a 2-flop synchronizer (sq1 then sq2), marked ASYNC_REG/DONT_TOUCH.
//    Rising edge = sq1 & ~sq2. Never use ro_in directly.
//  - Accurate counting requires f_ro < f_clk/2. Higher RO frequencies alias; this is not detected.
//  - FSM states: IDLE, SETTLE, MEASURE, DONE.
//  - IDLE: when start=1 at edge k, latch gate_len and go to SETTLE. ro_en=1 from after edge k.
//  - SETTLE: run SETTLE_CYCLES cycles; edges are ignored.
//    * After edge k+SETTLE_CYCLES, go to MEASURE and clear the edge counter.
//    * If the latched gate_len=0, go straight to DONE instead, with count=0.
//  - MEASURE: lasts exactly gate_len cycles. Each cycle with a detected rising edge adds 1.
//    * The counter saturates at 2^CNT_W-1 and sets the sticky overflow.
//    * After edge k+SETTLE_CYCLES+gate_len: load count, set valid=1, clear ro_en, go to DONE.
//  - Latency: valid first goes high SETTLE_CYCLES+gate_len cycles after the start edge.
//    ro_en is high for exactly that many cycles.
//  - DONE: count, overflow and valid hold stable until valid&ready is sampled; then go to IDLE.
//    valid=0 on the next cycle. valid&ready in the first DONE cycle is legal.
//  - start is ignored in SETTLE, MEASURE and DONE; it is neither queued nor counted.
//  - A start in the same cycle as the ready handshake is ignored. start is taken no earlier than
//    the cycle after busy falls.
//  - count and overflow keep the last result after leaving DONE; both are cleared on the next
//    accepted start.
// TESTING
//  1. rst_n=0 for 3 cycles with ro_in toggling -> ro_en=busy=valid=overflow=0, count=0.
//  2. ro_in period 10 clk, gate_len=100, SETTLE=4 -> valid 104 cycles after start, count=10 (+/-1),
//     overflow=0.
//  3. CNT_W=4, ro_in period 4 clk, gate_len=100 -> count=15, overflow=1.
//  4. ready=0 for 20 cycles after valid, start pulsed meanwhile -> outputs stable, no new run;
//     ready=1 -> valid=0 next cycle, busy=0.
//  5. gate_len=0 -> valid after SETTLE_CYCLES cycles with count=0; ro_en high 4 cycles.
//  6. rst_n=0 mid-MEASURE -> ro_en=0, busy=0 next edge; new start -> correct count as in test 2.

Source files
------------

// File: rtl/ro_freq_counter_if.sv
// ro_freq_counter_if: request/result handshake bundle for the ring-oscillator frequency counter
interface ro_freq_counter_if #(parameter int CNT_W = 16, parameter int GATE_W = 16);
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              valid;
  logic              ready;
  modport master(output start, gate_len, ready, input busy, count, overflow, valid);
  modport slave(input start, gate_len, ready, output busy, count, overflow, valid);
endinterface

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: counts synchronized ring-oscillator rising edges over a programmable clk window
module ro_freq_counter #(
  parameter int CNT_W         = 16,
  parameter int GATE_W        = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ro_in,
  output logic              ro_en,
  ro_freq_counter_if.slave  bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  state_t state_q, state_d;
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic sq1_q;
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic sq2_q;
  logic              sq1_d, sq2_d, rise, overflow_q, overflow_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [GATE_W-1:0] gate_q, gate_d, gate_len_q, gate_len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, count_q, count_d, cnt_inc;
  always_comb begin
    sq1_d      = ro_in;
    sq2_d      = sq1_q;
    rise       = sq1_q & ~sq2_q;
    cnt_inc    = &cnt_q ? cnt_q : cnt_q + CNT_W'(rise);
    state_d    = state_q;
    settle_d   = settle_q;
    gate_d     = gate_q;
    gate_len_d = gate_len_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d    = SETTLE;
        gate_len_d = bus.gate_len;
        settle_d   = '0;
        count_d    = '0;
        overflow_d = 1'b0;
      end
      SETTLE: if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
        state_d = (gate_len_q == '0) ? DONE : MEASURE;
        cnt_d   = '0;
        gate_d  = '0;
      end else settle_d = settle_q + 1'b1;
      MEASURE: begin
        cnt_d      = cnt_inc;
        overflow_d = overflow_q | (&cnt_q & rise);
        gate_d     = gate_q + 1'b1;
        if (gate_q == gate_len_q - 1'b1) begin
          state_d = DONE;
          count_d = cnt_inc;
        end
      end
      DONE: if (bus.ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sq1_q      <= 1'b0;
      sq2_q      <= 1'b0;
      settle_q   <= '0;
      gate_q     <= '0;
      gate_len_q <= '0;
      cnt_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sq1_q      <= sq1_d;
      sq2_q      <= sq2_d;
      settle_q   <= settle_d;
      gate_q     <= gate_d;
      gate_len_q <= gate_len_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign ro_en        = (state_q == SETTLE) || (state_q == MEASURE);
  assign bus.busy     = state_q != IDLE;
  assign bus.valid    = state_q == DONE;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: directed scoreboard bench for ro_freq_counter (16-bit and 4-bit counter instances)
module tb_ro_freq_counter;
  localparam int SET = 4;
  localparam int BUDGET = 400;
  typedef struct {int lo; int hi; int ovf; int lat;} exp_t;
  exp_t sb[$];
  logic clk = 1'b0, rst_n = 1'b0, ro_in = 1'b0, start = 1'b0, ready = 1'b0, sel = 1'b0;
  logic [15:0] gate_len = '0;
  logic ro_en0, ro_en1, ro_en, valid, busy, ovf;
  int count, ro_half = 20, checks = 0, errors = 0;
  ro_freq_counter_if #(.CNT_W(16), .GATE_W(16)) if0 ();
  ro_freq_counter_if #(.CNT_W(4), .GATE_W(16)) if1 ();
  ro_freq_counter #(.CNT_W(16), .GATE_W(16), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en0), .bus(if0));
  ro_freq_counter #(.CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(SET)) dut4 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en1), .bus(if1));
  assign if0.start = start & ~sel;
  assign if1.start = start & sel;
  assign if0.gate_len = gate_len;
  assign if1.gate_len = gate_len;
  assign if0.ready = ready;
  assign if1.ready = ready;
  always_comb begin
    ro_en = sel ? ro_en1 : ro_en0;
    valid = sel ? if1.valid : if0.valid;
    busy  = sel ? if1.busy : if0.busy;
    ovf   = sel ? if1.overflow : if0.overflow;
    count = sel ? int'(if1.count) : int'(if0.count);
  end
  always #5 clk = ~clk;
  initial begin
    #3;
    forever begin
      #(ro_half);
      ro_in = ~ro_in;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask
  task automatic launch(input int gl);
    gate_len = 16'(gl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic measure(input int gl, input int lo, input int hi, input int ov);
    int n, en;
    exp_t e;
    sb.push_back('{lo, hi, ov, SET + gl});
    launch(gl);
    n = 0;
    en = 0;
    while (!valid && n < BUDGET) begin
      en += int'(ro_en);
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("ro_en_cycles", en, e.lat);
    chk_range("count", count, e.lo, e.hi);
    chk("overflow", int'(ovf), e.ovf);
  endtask
  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("valid_after_ready", int'(valid), 0);
    chk("busy_after_ready", int'(busy), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ro_en", int'(ro_en0 | ro_en1), 0);
    chk("rst_busy", int'(if0.busy | if1.busy), 0);
    chk("rst_valid", int'(if0.valid | if1.valid), 0);
    chk("rst_overflow", int'(if0.overflow | if1.overflow), 0);
    chk("rst_count", int'(if0.count) + int'(if1.count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    ro_half = 50;
    measure(100, 9, 11, 0);
    accept();
    chk_range("count_held_after_done", count, 9, 11);
    sel = 1'b1;
    ro_half = 20;
    @(negedge clk);
    measure(100, 15, 15, 1);
    accept();
    sel = 1'b0;
    ro_half = 50;
    @(negedge clk);
    measure(100, 9, 11, 0);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      @(negedge clk);
      chk("done_hold_valid", int'(valid), 1);
    end
    chk_range("done_hold_count", count, 9, 11);
    chk("done_hold_overflow", int'(ovf), 0);
    start = 1'b1;
    accept();
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_queued_start", int'(busy), 0);
    measure(0, 0, 0, 0);
    accept();
    launch(100);
    repeat (50) @(negedge clk);
    chk("mid_measure_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ro_en", int'(ro_en), 0);
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    measure(100, 9, 11, 0);
    accept();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
